// File: rtl/priority_arb_mux_pkg.sv
// Shared helpers for priority_arb_mux: index width and one-hot utilities.
// Functions work on a fixed MAXW-bit vector; callers zero-extend and truncate.
package priority_arb_mux_pkg;

  localparam int unsigned MAXW = 128;

  function automatic int unsigned idx_w(input int unsigned cnt);
    return (cnt <= 1) ? 1 : $clog2(cnt);
  endfunction

  function automatic logic [7:0] oh2idx(input logic [MAXW-1:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (oh[i]) idx |= 8'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAXW-1:0] first_one(input logic [MAXW-1:0] v);
    return v & (~v + MAXW'(1));
  endfunction

endpackage

// File: rtl/priority_arb_mux_if.sv
// Request/response bundle between register-access sources, the arbiter and the bus port.
interface priority_arb_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT   = 5
);
  localparam int unsigned IDX_W = priority_arb_mux_pkg::idx_w(CNT);

  logic [CNT-1:0]       req_vld;
  logic [WIDTH*CNT-1:0] req_data;
  logic [CNT-1:0]       req_rdy;
  logic                 out_vld;
  logic [WIDTH-1:0]     out_data;
  logic [CNT-1:0]       out_sel;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_rdy;

  modport master (
    output req_vld, req_data, out_rdy,
    input  req_rdy, out_vld, out_data, out_sel, out_idx
  );

  modport slave (
    input  req_vld, req_data, out_rdy,
    output req_rdy, out_vld, out_data, out_sel, out_idx
  );

endinterface

// File: rtl/priority_arb_mux_grant.sv
// Combinational one-hot winner search starting at ptr, wrapping modulo CNT.
module priority_arb_grant
  import priority_arb_mux_pkg::*;
#(
  parameter int unsigned CNT = 5
) (
  input  logic [CNT-1:0]          req_vld,
  input  logic [idx_w(CNT)-1:0]   ptr,
  output logic [CNT-1:0]          grant
);
  localparam int unsigned DW = 2 * CNT;

  logic [DW-1:0] dbl;
  logic [DW-1:0] hit;

  // Low copy masked below ptr, high copy unmasked: the first set bit of the
  // concatenation is the first requester at or after ptr, wrapping around.
  always_comb begin
    dbl = {req_vld, req_vld};
    for (int unsigned i = 0; i < CNT; i++) begin
      if (i < 32'(ptr)) dbl[i] = 1'b0;
    end
    hit   = DW'(first_one(MAXW'(dbl)));
    grant = hit[CNT-1:0] | hit[DW-1:CNT];
  end

endmodule

// File: rtl/priority_arb_mux.sv
// Registered valid/ready arbiter-mux: CNT request channels into one output register.
// Define PRIORITY_ARB_MUX_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
module priority_arb_mux
  import priority_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT   = 5
) (
  input  logic              clk,
  input  logic              rst,
  priority_arb_mux_if.slave bus
);
  localparam int unsigned IDX_W = idx_w(CNT);

  logic [CNT-1:0]   grant;
  logic [CNT-1:0]   req_rdy;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             load;
  logic [WIDTH-1:0] data_mux;

  logic             out_vld_q,  out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT-1:0]   out_sel_q,  out_sel_d;
  logic [IDX_W-1:0] out_idx_q,  out_idx_d;

  priority_arb_grant #(.CNT(CNT)) u_grant (
    .req_vld (bus.req_vld),
    .ptr     (ptr),
    .grant   (grant)
  );

  assign load    = ~out_vld_q | bus.out_rdy;
  assign req_rdy = rst ? '0 : (grant & {CNT{load}});
  assign win_idx = IDX_W'(oh2idx(MAXW'(grant)));

  always_comb begin
    data_mux = '0;
    for (int unsigned c = 0; c < CNT; c++) begin
      data_mux |= bus.req_data[c*WIDTH +: WIDTH] & {WIDTH{grant[c]}};
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    out_idx_d  = out_idx_q;
    if (load) begin
      out_vld_d = |grant;
      if (|grant) begin
        out_data_d = data_mux;
        out_sel_d  = grant;
        out_idx_d  = win_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_idx_q  <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      out_idx_q  <= out_idx_d;
    end
  end

`ifdef PRIORITY_ARB_MUX_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             xfer;

  assign xfer = |req_rdy;

  // Next search starts just past the channel that transferred.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (win_idx == IDX_W'(CNT - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign bus.req_rdy  = req_rdy;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_sel  = out_sel_q;
  assign bus.out_idx  = out_idx_q;

endmodule

// File: doc/priority_arb_mux.md
# priority_arb_mux

Registered, handshaked successor to the combinational priority mux. Arbitrates among CNT valid/ready request channels of WIDTH bits each, grants at most one per cycle, and holds the winning payload in a single output register until the consumer accepts it. Arbitration is fixed-priority, with lowest index winning, or round-robin when compiled in. It sits between register-access sources and a shared downstream bus port.

## Interface
- WIDTH, 32, payload width per channel
- CNT, 5, number of request channels (≥1)
- IDX_W, derived, max(1, $clog2(CNT)); not overridden
---
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_vld  in  CNT  per-channel request valid
- req_data  in  WIDTH*CNT  flat payloads; channel c at [c*WIDTH +: WIDTH]
- req_rdy  out  CNT  per-channel accept (combinational)
- out_vld  out  1  output register holds a valid payload
- out_data  out  WIDTH  registered winning payload
- out_sel  out  CNT  registered one-hot of winning channel
- out_idx  out  IDX_W  registered binary index of winning channel
- out_rdy  in  1  consumer accept

## Operation
- load = ~out_vld | out_rdy. The output register may accept a new winner when it is empty or drained this cycle.
- grant = one-hot winner of req_vld under the current arbitration policy. It is all-zero when req_vld == 0.
- req_rdy = grant & {CNT{load}}. A channel transfers when req_vld[c] & req_rdy[c]. At most one bit of req_rdy is set.
- On load with a grant: out_vld←1, out_data←req_data[winner], out_sel←grant, out_idx←winner.
- On load without a grant: out_vld←0. out_data, out_sel and out_idx hold their previous values.
- With ~load, the output holds. out_vld, out_data, out_sel and out_idx are stable while out_vld & ~out_rdy.
- Fixed priority: the lowest-index asserted req_vld wins.
- Round-robin (macro set) uses pointer ptr (IDX_W bits).
  - The candidate search starts at ptr and wraps modulo CNT.
  - After a transfer from channel i, ptr←(i+1) mod CNT. When i = CNT-1, ptr wraps to 0.
  - ptr holds when there is no transfer.
- Requesters may drop req_vld without a transfer; the block imposes no hold requirement on them.
- CNT=1: grant = req_vld[0]; ptr is constant 0.

## Timing
- Reset values: out_vld=0, out_data=0, out_sel=0, out_idx=0, ptr=0.
- Reset overrides any concurrent transfer. A request presented in the reset cycle is not accepted: req_rdy is forced 0 while rst=1.
- Latency: request accepted in cycle N appears on out_* in cycle N+1.
- Throughput: one transfer per cycle when out_rdy is held high.
- Back-to-back transfers: when out_vld & out_rdy in a cycle, a new winner is loaded in that same cycle, with no bubble.
- req_rdy depends combinationally on req_vld, out_vld, out_rdy and ptr. There is no combinational path from req_data to any output.

## Configuration
- PRIORITY_ARB_MUX_RR_EN defined: round-robin arbitration with the ptr register as specified.
- PRIORITY_ARB_MUX_RR_EN undefined: fixed priority, lowest index wins. No ptr register is built and the masked search is removed.

## Structure
- Package priority_arb_mux_pkg holds:
  - function idx_w(cnt), returning max(1, $clog2(cnt))
  - function oh2idx, one-hot to binary
  - function first_one, lowest-set-bit one-hot
- Sub-module priority_arb_grant (combinational):
  - Inputs: req_vld, ptr.
  - Output: grant one-hot.
  - Implementation: double-width masked search.
  - The fixed-priority variant ties ptr to 0.
- The top level contains the output register, load logic, ptr update and the payload mux. The payload mux is an AND-OR select using out-of-register grant.

## Test plan
- Reset with req_vld=5'b11111 held → req_rdy=0 during reset; out_vld=0, out_sel=0, out_idx=0 in the cycle after reset release.
- Fixed priority, CNT=5, req_vld=5'b10110, out_rdy=1 → accept order 1, 2, 4 on consecutive cycles, with out_idx=1, 2, 4 one cycle later.
- Back-pressure: out_rdy=0 for 3 cycles after a grant of ch 2 (data 32'hA5A5_0002) → out_* stable and req_rdy=0. out_rdy=1 → ch 2 consumed and the next winner loaded in the same cycle.
- RR_EN, req_vld=5'b11111, out_rdy=1 → grants 0,1,2,3,4,0 with a wrap at 4→0. Drop ch 1 after its grant → sequence continues 2,3,4,0,2.
- RR_EN, ptr=3, only ch 0 requesting → ch 0 granted and ptr←1. No requests for 2 cycles → ptr stays 1 and out_vld falls to 0 once drained.
- CNT=1, WIDTH=8: req_vld toggling with out_rdy=1 → out_data follows req_data with 1-cycle latency and out_idx=0 throughout.
